// File: rtl/dmem_rmw_if.sv
// Signal bundle between the MEM stage, dmem_rmw_ctrl and the word-wide dmem.
// slave = the sequencer; master = the pipeline/memory side driving it.
interface dmem_rmw_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              stall;

  logic [ADDR_W-1:0] mem_ra;
  logic [31:0]       mem_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [31:0]       mem_wd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
           mem_ra, mem_we, mem_wa, mem_wd
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall,
           mem_ra, mem_we, mem_wa, mem_wd
  );
endinterface

// File: rtl/dmem_rmw_ctrl.sv
// Byte/half/word load-store sequencer onto an aligned word dmem; sub-word stores use read-modify-write.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned/illegal requests return rsp_err with no mem access.
module dmem_rmw_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  dmem_rmw_if.slave bus
);
  // state | meaning
  // IDLE  | ready to accept a request
  // RD    | aligned word read; load lane extract or store merge
  // WR    | full or merged word written to dmem
  // DONE  | one-cycle response strobe
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, ra_q, wa_q;
  logic [1:0]        size_q;
  logic              we_q, uns_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rdata_q, wd_q;

  logic              accept, req_bad, req_word;
  logic [1:0]        req_size_eff;
  logic [ADDR_W-1:0] req_addr_al, addr_al;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext, merged;
  logic              ready_c, stall_c, mem_we_c, rsp_valid_c;

  assign accept       = bus.req_valid && (state_q == IDLE);
  // size 11 only reaches the datapath when it is not trapped; it then behaves as a word
  assign req_size_eff = (bus.req_size == 2'b11) ? SZ_WORD : bus.req_size;
  assign req_word     = (req_size_eff == SZ_WORD);
  assign req_addr_al  = {bus.req_addr[ADDR_W-1:2], 2'b00};
  assign addr_al      = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  assign req_bad = (bus.req_size == 2'b11) ||
                   ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                   ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= req_bad;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign req_bad     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    stall_c     = 1'b1;
    mem_we_c    = 1'b0;
    rsp_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        stall_c = 1'b0;
        if (accept) begin
          if (req_bad) begin
            state_d = DONE;
          end else if (bus.req_we && req_word) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        state_d = we_q ? WR : DONE;
      end
      WR: begin
        mem_we_c = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        rsp_valid_c = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane extract for loads and lane replace for sub-word stores, both from the live read word
  always_comb begin
    lane_b = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

    case (size_q)
      SZ_BYTE: load_ext = {{24{lane_b[7] & ~uns_q}}, lane_b};
      SZ_HALF: load_ext = {{16{lane_h[15] & ~uns_q}}, lane_h};
      default: load_ext = bus.mem_rd;
    endcase

    merged = bus.mem_rd;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: begin
        if (addr_q[1]) begin
          merged[31:16] = wdata_q;
        end else begin
          merged[15:0] = wdata_q;
        end
      end
      default: merged = bus.mem_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= SZ_WORD;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ra_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        size_q  <= req_size_eff;
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        wdata_q <= bus.req_wdata[15:0];
        rdata_q <= '0;
        // mem_ra / mem_wa / mem_wd only move when the access will actually use them
        if (!req_bad && !(bus.req_we && req_word)) begin
          ra_q <= req_addr_al;
        end
        if (!req_bad && bus.req_we && req_word) begin
          wa_q <= req_addr_al;
          wd_q <= bus.req_wdata;
        end
      end
      if (state_q == RD) begin
        if (we_q) begin
          wa_q <= addr_al;
          wd_q <= merged;
        end else begin
          rdata_q <= load_ext;
        end
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.stall     = stall_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_ra    = ra_q;
  assign bus.mem_wa    = wa_q;
  assign bus.mem_wd    = wd_q;
endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
`timescale 1ns/1ps
// Bench for dmem_rmw_ctrl: directed accesses, mid-write reset and random traffic,
// scoreboarded against a word-array reference model.
module tb_dmem_rmw_ctrl;
  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic mem_clr = 1'b1;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_rmw_if #(.ADDR_W(32)) bus ();
  dmem_rmw_ctrl #(.ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] tb_mem  [64];
  logic [31:0] ref_mem [64];

  assign bus.mem_rd = tb_mem[bus.mem_ra[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= '0;
    end else if (bus.mem_we) begin
      tb_mem[bus.mem_wa[7:2]] <= bus.mem_wd;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk1(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: byte-addressed semantics on a word array, evaluated at accept time
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int acc);
    rsp_t        r;
    wr_t         w;
    logic [31:0] word, nw;
    logic [15:0] h;
    logic [7:0]  b;
    int          nbytes;
    bit          bad;
    int          idx;
    idx = int'(addr[7:2]);
    bad = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b00 && addr[1:0] != 2'b00);
`endif
    nbytes = (size == 2'b10) ? 1 : (size == 2'b01) ? 2 : 4;
    word   = ref_mem[idx];
    r.acc   = acc;
    r.rdata = '0;
    r.err   = bad;
    if (bad) begin
      r.lat = 1;
    end else if (we) begin
      nw = word;
      if (nbytes == 4) nw = wdata;
      else if (nbytes == 2) nw[16*int'(addr[1]) +: 16] = wdata[15:0];
      else nw[8*int'(addr[1:0]) +: 8] = wdata[7:0];
      r.lat  = (nbytes == 4) ? 2 : 3;
      w.addr = {addr[31:2], 2'b00};
      w.data = nw;
      w.cyc  = acc + r.lat - 1;
      wr_q.push_back(w);
      ref_mem[idx] = nw;
    end else begin
      r.lat = 2;
      if (nbytes == 4) begin
        r.rdata = word;
      end else if (nbytes == 2) begin
        h = word[16*int'(addr[1]) +: 16];
        r.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
      end else begin
        b = word[8*int'(addr[1:0]) +: 8];
        r.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
      end
    end
    rsp_q.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT writes memory or strobes a response
  rsp_t mr;
  wr_t  mw;
  int   stall_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
    end else begin
      if (bus.stall) stall_cnt++;
      chk1("ready_vs_stall", bus.req_ready, !bus.stall);
      if (bus.mem_we) begin
        if (wr_q.size() == 0) begin
          chk1("unexpected_write", bus.mem_we, 1'b0);
        end else begin
          mw = wr_q.pop_front();
          chk("wr_addr", bus.mem_wa, mw.addr);
          chk("wr_data", bus.mem_wd, mw.data);
          chk("wr_cycle", cyc, mw.cyc);
        end
      end
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk1("unexpected_rsp", bus.rsp_valid, 1'b0);
        end else begin
          mr = rsp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, mr.rdata);
          chk1("rsp_err", bus.rsp_err, mr.err);
          chk("rsp_latency", cyc - mr.acc, mr.lat);
          chk("stall_cycles", stall_cnt, mr.lat);
        end
        stall_cnt = 0;
      end
    end
  end

  // Leaves req_valid high after the accept; the DUT must ignore it while busy
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output int acc);
    int n;
    n = 0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      chk1("accept_timeout", bus.req_ready, 1'b1);
      bus.req_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      model(we, size, uns, addr, wdata, acc);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int k);
    bus.req_valid = 1'b0;
    repeat (k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.req_valid = 1'b0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk("drain_timeout", rsp_q.size() + wr_q.size(), 0);
      rsp_q.delete();
      wr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc1, acc2;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("reset_ready", bus.req_ready, 1'b1);
    chk1("reset_stall", bus.stall, 1'b0);
    chk1("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("reset_rsp_err", bus.rsp_err, 1'b0);
    chk1("reset_mem_we", bus.mem_we, 1'b0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_mem_ra", bus.mem_ra, 32'h0);
    chk("reset_mem_wa", bus.mem_wa, 32'h0);
    chk("reset_mem_wd", bus.mem_wd, 32'h0);
    @(posedge clk); #1;

    issue(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, acc);
    issue(1'b1, 2'b10, 1'b0, 32'h12, 32'h00000055, acc);
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, acc);
    drain();
    chk("sb_merged_word", tb_mem[4], 32'hDE55BEEF);

    issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h80F17F01, acc);
    issue(1'b0, 2'b10, 1'b0, 32'h23, 32'h0, acc);
    issue(1'b0, 2'b10, 1'b1, 32'h23, 32'h0, acc);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, acc);
    issue(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, acc);
    drain();

    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, acc);
    issue(1'b1, 2'b01, 1'b0, 32'h31, 32'h0000BEEF, acc);
    drain();
    chk("sh_0x31_word", tb_mem[12], ref_mem[12]);

    issue(1'b1, 2'b10, 1'b0, 32'h44, 32'h00000011, acc1);
    issue(1'b1, 2'b10, 1'b0, 32'h45, 32'h00000022, acc2);
    chk("b2b_accept_gap", acc2 - acc1, 4);
    drain();

    // Reset asserted during the WR cycle, before the committing edge
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk1("rst_pre_mem_we", bus.mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_mem_we_async", bus.mem_we, 1'b0);
    chk1("rst_stall_async", bus.stall, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk1("rst_no_rsp", bus.rsp_valid, 1'b0);
    end
    chk1("rst_ready_after", bus.req_ready, 1'b1);
    chk("rst_word_kept", tb_mem[16], ref_mem[16]);

    for (int k = 0; k < 300; k++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, acc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    for (int i = 0; i < 64; i++) chk($sformatf("mem_word_%0d", i), tb_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
